ex_mem_pipe_stage: RTL and testbench

//  Elastic EX->MEM pipeline register carrying ALU result, store data, dest reg and ctrl bits.

---
 rtl/mips_pipe_pkg.sv | 26 ++
 rtl/pipe_skid_buf.sv | 94 +++++++++
 rtl/ex_mem_pipe_stage.sv | 79 +++++++
 tb/tb_ex_mem_pipe_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS-32 pipeline definitions: control-bit positions, default widths
// and the state encoding of the 2-entry elastic stage.
package mips_pipe_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF     = 4;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  // A held result can be bypassed only if it writes a real (non-r0) register.
  function automatic logic fwd_hit(input logic valid, input logic reg_write,
                                   input logic rd_nonzero);
    return valid & reg_write & rd_nonzero;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: main entry drives the output, skid absorbs one
// extra beat so in_ready can be a flop with no path from out_ready.
module pipe_skid_buf
  import mips_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  skid_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 in_ready_q, in_ready_d;
  logic                 xfer_in_s, xfer_out_s;

  assign xfer_in_s  = in_valid & in_ready_q;
  assign xfer_out_s = (state_q != ST_EMPTY) & out_ready;

  // Next-state and payload steering; flush only drops the valid state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer_in_s) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (xfer_in_s && xfer_out_s) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end else if (xfer_out_s) begin
          state_d = ST_EMPTY;
        end else if (xfer_in_s) begin
          skid_d  = in_data;
          state_d = ST_TWO;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (xfer_out_s) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_d;
    end
    in_ready_d = (state_d != ST_TWO);
  end

  // State, payload and registered ready.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM elastic pipeline register: skid-buffered payload, EX bypass tap and
// a saturating back-pressure cycle counter.
module ex_mem_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int CTRL_W      = CTRL_W_DEF,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_alu_result,
  input  logic [DATA_W-1:0]      in_store_data,
  input  logic [REG_ADDR_W-1:0]  in_rd,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_alu_result,
  output logic [DATA_W-1:0]      out_store_data,
  output logic [REG_ADDR_W-1:0]  out_rd,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic                   fwd_valid,
  output logic [REG_ADDR_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0]      fwd_data,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int PAYLOAD_W = CTRL_W + REG_ADDR_W + 2 * DATA_W;

  logic [PAYLOAD_W-1:0]   in_pl_s, out_pl_s;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  assign in_pl_s = {in_ctrl, in_rd, in_store_data, in_alu_result};

  pipe_skid_buf #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_pl_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_pl_s)
  );

  assign {out_ctrl, out_rd, out_store_data, out_alu_result} = out_pl_s;

  assign fwd_valid = fwd_hit(out_valid, out_ctrl[CTRL_REG_WRITE], (out_rd != '0));
  assign fwd_rd    = out_rd;
  assign fwd_data  = out_alu_result;

  // Count stalled cycles, sticking at all-ones; flush leaves it alone.
  always_comb begin
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Self-checking bench for ex_mem_pipe_stage: vector table plus scoreboard model.
module tb_ex_mem_pipe_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          reset_n, flush, in_valid, in_ready, out_valid, out_ready, fwd_valid;
  logic [DW-1:0] in_alu_result, in_store_data, out_alu_result, out_store_data, fwd_data;
  logic [AW-1:0] in_rd, out_rd, fwd_rd;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [SW-1:0] stall_cycles;

  ex_mem_pipe_stage #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW), .STALL_CNT_W(SW)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_ctrl(out_ctrl),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] sd;
    logic [AW-1:0] rd;
    logic [CW-1:0] ctrl;
  } pl_t;

  typedef struct {
    logic          iv;
    logic [DW-1:0] alu;
    logic [AW-1:0] rd;
    logic [CW-1:0] ctrl;
    logic          ordy;
    logic          fl;
    logic          e_ov;
    logic          e_ir;
    logic [DW-1:0] e_alu;
  } vec_t;

  pl_t           m_q[$];
  logic [SW-1:0] m_stall;
  int            n_err = 0;
  int            n_chk = 0;
  vec_t          vecs[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle, check current outputs against the model, then advance the model.
  task automatic step(input logic iv, input logic [DW-1:0] a, input logic [AW-1:0] rd,
                      input logic [CW-1:0] ctrl, input logic ordy, input logic fl,
                      input logic rn);
    pl_t p;
    logic acc_in, acc_out;
    p = '{alu: a, sd: a ^ 32'hA5A5_0000, rd: rd, ctrl: ctrl};
    in_valid = iv; in_alu_result = p.alu; in_store_data = p.sd; in_rd = rd;
    in_ctrl = ctrl; out_ready = ordy; flush = fl; reset_n = rn;
    chk("out_valid", {63'd0, out_valid}, {63'd0, (m_q.size() > 0)});
    chk("in_ready", {63'd0, in_ready}, {63'd0, (m_q.size() < 2)});
    chk("stall_cycles", {60'd0, stall_cycles}, {60'd0, m_stall});
    if (m_q.size() > 0) begin
      chk("out_alu", {32'd0, out_alu_result}, {32'd0, m_q[0].alu});
      chk("out_sd", {32'd0, out_store_data}, {32'd0, m_q[0].sd});
      chk("out_rd", {59'd0, out_rd}, {59'd0, m_q[0].rd});
      chk("out_ctrl", {60'd0, out_ctrl}, {60'd0, m_q[0].ctrl});
      chk("fwd_valid", {63'd0, fwd_valid},
          {63'd0, (m_q[0].ctrl[0] && (m_q[0].rd != 5'd0))});
      chk("fwd_data", {32'd0, fwd_data}, {32'd0, m_q[0].alu});
      chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, m_q[0].rd});
    end else begin
      chk("fwd_valid_idle", {63'd0, fwd_valid}, 64'd0);
    end
    if (!rn) begin
      m_q.delete();
      m_stall = 4'd0;
    end else begin
      if (m_q.size() > 0 && !ordy && m_stall != 4'hF) m_stall = m_stall + 4'd1;
      if (fl) begin
        m_q.delete();
      end else begin
        acc_in  = iv && (m_q.size() < 2);
        acc_out = (m_q.size() > 0) && ordy;
        if (acc_out) void'(m_q.pop_front());
        if (acc_in) m_q.push_back(p);
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Streaming 1..4, then drain.
    vecs[0]  = '{1'b1, 32'h1,  5'd1, 4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1};
    vecs[1]  = '{1'b1, 32'h2,  5'd2, 4'h1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2};
    vecs[2]  = '{1'b1, 32'h3,  5'd3, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3};
    vecs[3]  = '{1'b1, 32'h4,  5'd4, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4};
    vecs[4]  = '{1'b0, 32'h0,  5'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    // Back-pressure: A then B fill, C refused, then A and B drain in order.
    vecs[5]  = '{1'b1, 32'h10, 5'd6, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10};
    vecs[6]  = '{1'b1, 32'h20, 5'd7, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10};
    vecs[7]  = '{1'b1, 32'h30, 5'd8, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10};
    vecs[8]  = '{1'b0, 32'h0,  5'd0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10};
    vecs[9]  = '{1'b0, 32'h0,  5'd0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20};
    vecs[10] = '{1'b0, 32'h0,  5'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    // Flush while full with a new entry offered.
    vecs[11] = '{1'b1, 32'h40, 5'd9, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40};
    vecs[12] = '{1'b1, 32'h50, 5'd10, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40};
    vecs[13] = '{1'b1, 32'h60, 5'd11, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'h0,  5'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_result = '0; in_store_data = '0; in_rd = '0; in_ctrl = '0;
    repeat (2) @(posedge clock);
    #1;
    m_stall = 4'd0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_alu", {32'd0, out_alu_result}, 64'd0);
    chk("rst_stall", {60'd0, stall_cycles}, 64'd0);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].iv, vecs[i].alu, vecs[i].rd, vecs[i].ctrl, vecs[i].ordy, vecs[i].fl, 1'b1);
      chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].e_ov});
      chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].e_ir});
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d_out_alu", i), {32'd0, out_alu_result}, {32'd0, vecs[i].e_alu});
      end
    end
    repeat (2) step(1'b0, 32'h0, 5'd0, 4'h0, 1'b1, 1'b0, 1'b1);

    // Forwarding tap.
    step(1'b1, 32'hDEAD, 5'd5, 4'b0001, 1'b0, 1'b0, 1'b1);
    chk("fwd_hit_valid", {63'd0, fwd_valid}, 64'd1);
    chk("fwd_hit_rd", {59'd0, fwd_rd}, 64'd5);
    chk("fwd_hit_data", {32'd0, fwd_data}, 64'hDEAD);
    step(1'b1, 32'hBEEF, 5'd0, 4'b0001, 1'b1, 1'b0, 1'b1);
    chk("fwd_rd0", {63'd0, fwd_valid}, 64'd0);
    step(1'b1, 32'hCAFE, 5'd7, 4'b0010, 1'b1, 1'b0, 1'b1);
    chk("fwd_nowrite", {63'd0, fwd_valid}, 64'd0);
    step(1'b0, 32'h0, 5'd0, 4'h0, 1'b1, 1'b0, 1'b1);

    // Saturation, then reset beating a simultaneous flush.
    step(1'b0, 32'h0, 5'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h77, 5'd3, 4'h9, 1'b0, 1'b0, 1'b1);
    repeat (20) step(1'b0, 32'h0, 5'd0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("stall_saturated", {60'd0, stall_cycles}, 64'd15);
    chk("sat_payload_held", {32'd0, out_alu_result}, 64'h77);
    step(1'b1, 32'h99, 5'd4, 4'h1, 1'b0, 1'b1, 1'b0);
    chk("rf_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rf_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rf_out_alu", {32'd0, out_alu_result}, 64'd0);
    chk("rf_out_rd", {59'd0, out_rd}, 64'd0);
    chk("rf_out_ctrl", {60'd0, out_ctrl}, 64'd0);
    chk("rf_stall", {60'd0, stall_cycles}, 64'd0);
    step(1'b0, 32'h0, 5'd0, 4'h0, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
